// File: rtl/cordic_pkg.sv
// Shared CORDIC definitions: FSM state encoding, arctangent table generator and default gain
// compensation constant, used by both the rotation and vectoring blocks.
package cordic_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StIter,
    StScale,
    StDone
  } cordic_state_e;

  // 1/An for 30 iterations, scaled by 2^30
  localparam logic signed [30:0] K_DEFAULT = 31'sd652032874;

  localparam real PI = 3.14159265358979323846;

  // Angle units put pi/2 at 2^bw, so entry 0 (pi/4) is exactly 2^(bw-1)
  function automatic longint atan_entry(input int bw, input int i);
    real r;
    r = $atan(2.0 ** (-i)) * (2.0 ** (bw + 1)) / PI;
    return longint'(r);
  endfunction

endpackage

// File: rtl/cordic_vector_data.sv
// Vectoring CORDIC datapath: x/y/z micro-rotations, angle clamp and optional K-scaled magnitude
// (built only when CORDIC_VECTOR_MAG_EN is defined).
module cordic_vector_data
  import cordic_pkg::*;
#(
  parameter int                        BIT_WIDTH       = 30,
  parameter int                        LOG_2_BIT_WIDTH = 5,
  parameter logic signed [BIT_WIDTH:0] K               = K_DEFAULT
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       i_load,
  input  logic                       i_iter,
  input  logic                       i_out_en,
  input  logic [LOG_2_BIT_WIDTH-1:0] i_cnt,
  input  logic [BIT_WIDTH-1:0]       i_x,
  input  logic [BIT_WIDTH-1:0]       i_y,
  output logic [BIT_WIDTH-1:0]       o_angle,
  output logic [BIT_WIDTH:0]         o_mag
);

  localparam int XW = BIT_WIDTH + 3;
  localparam int ZW = BIT_WIDTH + 2;
  localparam int NT = 2 ** LOG_2_BIT_WIDTH;

  logic signed [XW-1:0] r_x, r_y;
  logic signed [XW-1:0] w_x_sh, w_y_sh, w_x_nxt, w_y_nxt;
  logic signed [ZW-1:0] r_z, w_z_nxt, w_atan, w_z_src;
  logic signed [ZW-1:0] w_atan_tab [NT];
  logic [BIT_WIDTH-1:0] w_angle;
  logic                 r_zero;

  for (genvar g = 0; g < NT; g++) begin : g_atan
    if (g < BIT_WIDTH) begin : g_val
      localparam logic signed [ZW-1:0] ATAN_G = ZW'(atan_entry(BIT_WIDTH, g));
      assign w_atan_tab[g] = ATAN_G;
    end else begin : g_pad
      assign w_atan_tab[g] = '0;
    end
  end

  always_comb begin
    w_x_sh = r_x >>> i_cnt;
    w_y_sh = r_y >>> i_cnt;
    w_atan = w_atan_tab[i_cnt];
    if (!r_y[XW-1]) begin
      w_x_nxt = r_x + w_y_sh;
      w_y_nxt = r_y - w_x_sh;
      w_z_nxt = r_z + w_atan;
    end else begin
      w_x_nxt = r_x - w_y_sh;
      w_y_nxt = r_y + w_x_sh;
      w_z_nxt = r_z - w_atan;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_x    <= '0;
      r_y    <= '0;
      r_z    <= '0;
      r_zero <= 1'b0;
    end else if (i_load) begin
      r_x    <= XW'(i_x);
      r_y    <= XW'(i_y);
      r_z    <= '0;
      r_zero <= (i_x == '0) && (i_y == '0);
    end else if (i_iter) begin
      r_x <= w_x_nxt;
      r_y <= w_y_nxt;
      r_z <= w_z_nxt;
    end
  end

`ifdef CORDIC_VECTOR_MAG_EN
  assign w_z_src = r_z;
`else
  // Without SCALE the angle is captured on the last iteration edge itself
  assign w_z_src = w_z_nxt;
`endif

  always_comb begin
    if (w_z_src[ZW-1]) begin
      w_angle = '0;
    end else if (w_z_src[BIT_WIDTH]) begin
      w_angle = '1;
    end else begin
      w_angle = w_z_src[BIT_WIDTH-1:0];
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      o_angle <= '0;
    end else if (i_out_en) begin
      o_angle <= r_zero ? '0 : w_angle;
    end
  end

`ifdef CORDIC_VECTOR_MAG_EN
  localparam int PW = XW + BIT_WIDTH + 1;

  logic signed [PW-1:0] w_prod, w_prod_sh;
  logic [BIT_WIDTH:0]   w_mag;

  assign w_prod    = PW'(r_x) * PW'(K);
  assign w_prod_sh = w_prod >>> BIT_WIDTH;

  always_comb begin
    if (w_prod_sh[PW-1]) begin
      w_mag = '0;
    end else if (|w_prod_sh[PW-2:BIT_WIDTH+1]) begin
      w_mag = '1;
    end else begin
      w_mag = w_prod_sh[BIT_WIDTH:0];
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      o_mag <= '0;
    end else if (i_out_en) begin
      o_mag <= r_zero ? '0 : w_mag;
    end
  end
`else
  logic w_unused_k;
  assign w_unused_k = ^K;
  assign o_mag      = '0;
`endif

endmodule

// File: rtl/cordic_vector.sv
// Iterative vectoring-mode CORDIC: atan2 and gain-corrected magnitude of a quadrant-I point.
// Define CORDIC_VECTOR_MAG_EN to build the magnitude multiplier and the SCALE state.
module cordic_vector
  import cordic_pkg::*;
#(
  parameter int                        BIT_WIDTH       = 30,
  parameter int                        LOG_2_BIT_WIDTH = 5,
  parameter logic signed [BIT_WIDTH:0] K               = K_DEFAULT
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 start,
  input  logic [BIT_WIDTH-1:0] in_x,
  input  logic [BIT_WIDTH-1:0] in_y,
  output logic [BIT_WIDTH-1:0] out_angle,
  output logic [BIT_WIDTH:0]   out_mag,
  output logic                 ready,
  output logic                 done
);

  cordic_state_e              r_state;
  logic [LOG_2_BIT_WIDTH-1:0] r_cnt;
  logic                       w_load, w_iter, w_last, w_out_en;

  assign ready  = (r_state == StIdle) || (r_state == StDone);
  assign done   = (r_state == StDone);
  assign w_load = start && ready;
  assign w_iter = (r_state == StIter);
  assign w_last = w_iter && (r_cnt == LOG_2_BIT_WIDTH'(BIT_WIDTH - 1));

`ifdef CORDIC_VECTOR_MAG_EN
  assign w_out_en = (r_state == StScale);
`else
  assign w_out_en = w_last;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= StIdle;
      r_cnt   <= '0;
    end else begin
      case (r_state)
        StIdle, StDone: begin
          if (start) begin
            r_state <= StIter;
            r_cnt   <= '0;
          end
        end
        StIter: begin
          r_cnt <= r_cnt + 1'b1;
          if (w_last) begin
`ifdef CORDIC_VECTOR_MAG_EN
            r_state <= StScale;
`else
            r_state <= StDone;
`endif
          end
        end
        StScale: r_state <= StDone;
        default: r_state <= StIdle;
      endcase
    end
  end

  cordic_vector_data #(
    .BIT_WIDTH      (BIT_WIDTH),
    .LOG_2_BIT_WIDTH(LOG_2_BIT_WIDTH),
    .K              (K)
  ) u_data (
    .clk     (clk),
    .reset   (reset),
    .i_load  (w_load),
    .i_iter  (w_iter),
    .i_out_en(w_out_en),
    .i_cnt   (r_cnt),
    .i_x     (in_x),
    .i_y     (in_y),
    .o_angle (out_angle),
    .o_mag   (out_mag)
  );

endmodule

// File: tb/tb_cordic_vector.sv
// Bench for cordic_vector: directed and random quadrant-I points checked against an
// atan2/sqrt reference, plus handshake, latency, reset and input-isolation behaviour.
module tb_cordic_vector;

  localparam int BW = 30;
`ifdef CORDIC_VECTOR_MAG_EN
  localparam int LAT     = BW + 1;
  localparam int MAG_TOL = 8;
  localparam bit MAG_ON  = 1'b1;
`else
  localparam int LAT     = BW;
  localparam int MAG_TOL = 0;
  localparam bit MAG_ON  = 1'b0;
`endif
  localparam real PI  = 3.14159265358979323846;
  localparam int  TOL = 8;

  logic          clk = 1'b0;
  logic          reset, start;
  logic [BW-1:0] in_x, in_y, out_angle;
  logic [BW:0]   out_mag;
  logic          ready, done;

  int checks = 0;
  int errors = 0;

  cordic_vector #(
    .BIT_WIDTH      (BW),
    .LOG_2_BIT_WIDTH(5),
    .K              (31'sd652032874)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .start    (start),
    .in_x     (in_x),
    .in_y     (in_y),
    .out_angle(out_angle),
    .out_mag  (out_mag),
    .ready    (ready),
    .done     (done)
  );

  always #5 clk = ~clk;

  // Ideal angle in output units (pi/2 -> 2^BW), limited to the representable range
  function automatic real ref_angle(longint x, longint y);
    real a;
    if (x == 0 && y == 0) return 0.0;
    a = $atan2(real'(y), real'(x)) * (2.0 ** (BW + 1)) / PI;
    if (a > (2.0 ** BW) - 1.0) a = (2.0 ** BW) - 1.0;
    return a;
  endfunction

  function automatic real ref_mag(longint x, longint y);
    if (!MAG_ON) return 0.0;
    return $sqrt(real'(x) * real'(x) + real'(y) * real'(y));
  endfunction

  task automatic check_eq(input string tag, input longint got, input longint exp);
    checks++;
    assert (got === exp)
    else begin
      errors++;
      $error("FAIL %s got %0d want %0d", tag, got, exp);
    end
  endtask

  task automatic check_near(input string tag, input longint got, input real want, input int tol);
    real d;
    logic ok;
    d = real'(got) - want;
    if (d < 0.0) d = -d;
    ok = (d <= real'(tol));
    checks++;
    assert (ok === 1'b1)
    else begin
      errors++;
      $error("FAIL %s got %0d want %0.1f +/- %0d", tag, got, want, tol);
    end
  endtask

  // Called at a negedge; launches one computation and checks latency and results
  task automatic run_point(input string tag, input int unsigned x, input int unsigned y,
                           input bit disturb);
    int k;
    start = 1'b1;
    in_x  = BW'(x);
    in_y  = BW'(y);
    @(negedge clk);
    start = 1'b0;
    check_eq({tag, "_ready_low"}, longint'(ready), 0);
    check_eq({tag, "_done_low"}, longint'(done), 0);
    k = 0;
    while (done !== 1'b1 && k < 4 * LAT) begin
      @(negedge clk);
      k++;
      if (disturb && k == 5) begin
        start = 1'b1;
        in_x  = BW'($urandom);
        in_y  = BW'($urandom);
      end
      if (disturb && k == 6) start = 1'b0;
    end
    check_eq({tag, "_latency"}, longint'(k), longint'(LAT));
    check_near({tag, "_angle"}, longint'(out_angle), ref_angle(x, y), TOL);
    check_near({tag, "_mag"}, longint'(out_mag), ref_mag(x, y), MAG_TOL);
  endtask

  initial begin
    bit seen;
    int unsigned rx, ry;

    reset = 1'b1;
    start = 1'b0;
    in_x  = '0;
    in_y  = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check_eq("rst_ready", longint'(ready), 1);
    check_eq("rst_done", longint'(done), 0);
    check_eq("rst_angle", longint'(out_angle), 0);
    check_eq("rst_mag", longint'(out_mag), 0);
    reset = 1'b0;
    @(negedge clk);

    run_point("diag", 536870912, 536870912, 1'b0);
    repeat (3) @(negedge clk);
    check_eq("hold_done", longint'(done), 1);
    check_eq("hold_ready", longint'(ready), 1);
    check_near("hold_angle", longint'(out_angle), ref_angle(536870912, 536870912), TOL);

    run_point("deg30", 929887697, 536870912, 1'b0);
    run_point("x_axis", 1073741823, 0, 1'b0);
    run_point("y_axis", 0, 1073741823, 1'b0);
    run_point("zero", 0, 0, 1'b0);
    check_eq("zero_angle_exact", longint'(out_angle), 0);
    check_eq("zero_mag_exact", longint'(out_mag), 0);

    // Start issued straight from DONE, then inputs/start perturbed mid-iteration
    run_point("b2b", 700000000, 300000000, 1'b0);
    run_point("disturb", 400000000, 900000000, 1'b1);

    start = 1'b1;
    in_x  = BW'(800000000);
    in_y  = BW'(200000000);
    @(negedge clk);
    start = 1'b0;
    repeat (10) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    check_eq("midrst_ready", longint'(ready), 1);
    check_eq("midrst_done", longint'(done), 0);
    check_eq("midrst_angle", longint'(out_angle), 0);
    check_eq("midrst_mag", longint'(out_mag), 0);
    reset = 1'b0;
    seen  = 1'b0;
    repeat (LAT + 5) begin
      @(negedge clk);
      if (done === 1'b1) seen = 1'b1;
    end
    check_eq("midrst_no_done", longint'(seen), 0);

    for (int n = 0; n < 20; n++) begin
      rx = $urandom_range(1073741823, 268435456);
      ry = $urandom_range(1073741823, 268435456);
      run_point($sformatf("rand%0d", n), rx, ry, 1'b0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
